// File: rtl/iq_prog_delay_if.sv
`default_nettype none
// ============================================================================
// Module   : iq_prog_delay_if
// Brief    : Sample stream, delay configuration and status bundle for
//            iq_prog_delay.
// Revision : 1.0  initial release
// ============================================================================
interface iq_prog_delay_if #(
  parameter int W    = 18,
  parameter int NCH  = 4,
  parameter int MAXD = 16
);
  localparam int DW = $clog2(MAXD + 1);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic                din_valid;
  logic [NCH*W-1:0]    dinI;
  logic [NCH*W-1:0]    dinQ;
  logic                cfg_we;
  logic [CW-1:0]       cfg_ch;
  logic [DW-1:0]       cfg_delay;
  logic                dout_valid;
  logic [NCH*W-1:0]    doutI;
  logic [NCH*W-1:0]    doutQ;
  logic [NCH-1:0]      chan_blank;
  logic [NCH*DW-1:0]   delay_cur;

  modport master (
    output din_valid, dinI, dinQ, cfg_we, cfg_ch, cfg_delay,
    input  dout_valid, doutI, doutQ, chan_blank, delay_cur
  );

  modport slave (
    input  din_valid, dinI, dinQ, cfg_we, cfg_ch, cfg_delay,
    output dout_valid, doutI, doutQ, chan_blank, delay_cur
  );
endinterface
`default_nettype wire

// File: rtl/iq_prog_delay.sv
`default_nettype none
// ============================================================================
// Module   : iq_prog_delay
// Brief    : Multi-channel I/Q delay line, each channel delayed by its own
//            programmable 0..MAXD valid samples. Define DELAY_BLANK_EN to
//            blank a channel for MAXD valid samples after its delay changes.
// Revision : 1.0  initial release
// ============================================================================
module iq_prog_delay #(
  parameter int W         = 18,
  parameter int NCH       = 4,
  parameter int MAXD      = 16,
  parameter int DEF_DELAY = 2
) (
  input  wire logic      clk,
  input  wire logic      rst,
  iq_prog_delay_if.slave bus
);
  localparam int DW = $clog2(MAXD + 1);
  localparam int PW = (MAXD > 1) ? $clog2(MAXD) : 1;
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [DW-1:0] C_MAXD  = DW'(MAXD);
  localparam logic [DW:0]   C_MAXD1 = (DW + 1)'(MAXD);
  localparam logic [DW-1:0] C_DEF   = DW'(DEF_DELAY);
  localparam logic [PW-1:0] C_WLAST = PW'(MAXD - 1);

  logic [PW-1:0] r_wptr;
  logic          w_cfg_ok;
  logic [DW-1:0] w_cfg_val;

  // (wptr - d) mod MAXD, kept non-negative by biasing with MAXD first
  function automatic logic [PW-1:0] rd_index(input logic [PW-1:0] wp,
                                             input logic [DW-1:0] d);
    logic [DW:0] s;
    s = {1'b0, DW'(wp)} + C_MAXD1 - {1'b0, d};
    if (s >= C_MAXD1) s = s - C_MAXD1;
    return s[PW-1:0];
  endfunction

  assign w_cfg_ok  = bus.cfg_we && (32'(bus.cfg_ch) < NCH);
  assign w_cfg_val = (bus.cfg_delay > C_MAXD) ? C_MAXD : bus.cfg_delay;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr         <= '0;
      bus.dout_valid <= 1'b0;
    end else begin
      bus.dout_valid <= bus.din_valid;
      if (bus.din_valid) r_wptr <= (r_wptr == C_WLAST) ? '0 : r_wptr + PW'(1);
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [2*W-1:0] r_mem [MAXD];
    logic [DW-1:0]  r_delay;
    logic [W-1:0]   r_outI;
    logic [W-1:0]   r_outQ;
    logic [W-1:0]   w_inI;
    logic [W-1:0]   w_inQ;
    logic [PW-1:0]  w_ridx;
    logic           w_sel;
    logic           w_blank;

    assign w_inI  = bus.dinI[c*W +: W];
    assign w_inQ  = bus.dinQ[c*W +: W];
    assign w_sel  = w_cfg_ok && (bus.cfg_ch == CW'(c));
    assign w_ridx = rd_index(r_wptr, r_delay);

    always_ff @(posedge clk or posedge rst) begin
      if (rst)        r_delay <= C_DEF;
      else if (w_sel) r_delay <= w_cfg_val;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < MAXD; i++) r_mem[i] <= '0;
      end else if (bus.din_valid) begin
        r_mem[r_wptr] <= {w_inI, w_inQ};
      end
    end

`ifdef DELAY_BLANK_EN
    logic [DW-1:0] r_blank;

    // A reload takes priority over the per-sample decrement
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        r_blank <= '0;
      else if (w_sel && (w_cfg_val != r_delay))
        r_blank <= C_MAXD;
      else if (bus.din_valid && (r_blank != '0))
        r_blank <= r_blank - DW'(1);
    end

    assign w_blank = (r_blank != '0);
`else
    assign w_blank = 1'b0;
`endif

    // Read happens before this cycle's write, so delay 0 bypasses the buffer
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_outI <= '0;
        r_outQ <= '0;
      end else if (bus.din_valid) begin
        if (w_blank) begin
          r_outI <= '0;
          r_outQ <= '0;
        end else if (r_delay == '0) begin
          r_outI <= w_inI;
          r_outQ <= w_inQ;
        end else begin
          {r_outI, r_outQ} <= r_mem[w_ridx];
        end
      end
    end

    assign bus.doutI[c*W +: W]      = r_outI;
    assign bus.doutQ[c*W +: W]      = r_outQ;
    assign bus.chan_blank[c]        = w_blank;
    assign bus.delay_cur[c*DW +: DW] = r_delay;
  end
endmodule
`default_nettype wire

// File: tb/tb_iq_prog_delay.sv
`default_nettype none
// ============================================================================
// Module   : tb_iq_prog_delay
// Brief    : Scoreboard bench for iq_prog_delay: a driver pushes expected
//            outputs from a sample-history model, a monitor pops and compares.
// Revision : 1.0  initial release
// ============================================================================
module tb_iq_prog_delay;
  localparam int W    = 18;
  localparam int NCH  = 4;
  localparam int MAXD = 16;
  localparam int DEF  = 2;
  localparam int DW   = 5;
  localparam int CW   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iq_prog_delay_if #(.W(W), .NCH(NCH), .MAXD(MAXD)) bus ();
  iq_prog_delay #(.W(W), .NCH(NCH), .MAXD(MAXD), .DEF_DELAY(DEF)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  iq_prog_delay_if #(.W(W), .NCH(3), .MAXD(MAXD)) bus3 ();
  iq_prog_delay #(.W(W), .NCH(3), .MAXD(MAXD), .DEF_DELAY(DEF)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3)
  );

  typedef struct {
    logic [NCH*W-1:0] i;
    logic [NCH*W-1:0] q;
  } exp_t;

  exp_t             sb[$];
  int               total = 0;
  int               bad   = 0;
  logic [W-1:0]     hI [NCH][1024];
  logic [W-1:0]     hQ [NCH][1024];
  int               n;
  int               md [NCH];
  int               mb [NCH];
  logic [NCH*W-1:0] lastI;
  logic [NCH*W-1:0] lastQ;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  task automatic model_reset();
    n = 0;
    for (int c = 0; c < NCH; c++) begin
      md[c] = DEF;
      mb[c] = 0;
    end
    lastI = '0;
    lastQ = '0;
    sb.delete();
  endtask

  // One clock of stimulus; the sample (if any) uses the delays in force before
  // this cycle's configuration write.
  task automatic cycle(input bit v, input bit we, input int ch, input int dly);
    exp_t              e;
    logic [NCH*DW-1:0] ed;
    logic [NCH-1:0]    eb;
    logic [W-1:0]      vi, vq;
    int                nd;
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      ed[c*DW +: DW] = DW'(md[c]);
      eb[c]          = (mb[c] != 0);
    end
    chk("delay_cur", 128'(bus.delay_cur), 128'(ed));
    chk("chan_blank", 128'(bus.chan_blank), 128'(eb));
    bus.din_valid = v;
    bus.cfg_we    = we;
    bus.cfg_ch    = CW'(ch);
    bus.cfg_delay = DW'(dly);
    for (int c = 0; c < NCH; c++) begin
      vi = W'(1000 + n + 100 * c);
      vq = W'(-(3 * n + 5 + 37 * c));
      bus.dinI[c*W +: W] = vi;
      bus.dinQ[c*W +: W] = vq;
      if (v) begin
        hI[c][n] = vi;
        hQ[c][n] = vq;
      end
    end
    if (v) begin
      for (int c = 0; c < NCH; c++) begin
        if (mb[c] != 0 || n < md[c]) begin
          e.i[c*W +: W] = '0;
          e.q[c*W +: W] = '0;
        end else begin
          e.i[c*W +: W] = hI[c][n - md[c]];
          e.q[c*W +: W] = hQ[c][n - md[c]];
        end
        if (mb[c] > 0) mb[c]--;
      end
      sb.push_back(e);
      n++;
    end
    if (we && ch < NCH) begin
      nd = (dly > MAXD) ? MAXD : dly;
`ifdef DELAY_BLANK_EN
      if (nd != md[ch]) mb[ch] = MAXD;
`endif
      md[ch] = nd;
    end
  endtask

  always @(posedge clk) begin
    exp_t m;
    #1;
    if (!rst) begin
      if (bus.dout_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_dout_valid: got 1 required 0");
        end else begin
          m = sb.pop_front();
          chk("doutI", 128'(bus.doutI), 128'(m.i));
          chk("doutQ", 128'(bus.doutQ), 128'(m.q));
          lastI = m.i;
          lastQ = m.q;
        end
      end else begin
        chk("latency_pending", 128'(sb.size()), 128'(0));
        chk("holdI", 128'(bus.doutI), 128'(lastI));
        chk("holdQ", 128'(bus.doutQ), 128'(lastQ));
      end
    end
  end

  initial begin
    bus.din_valid  = 1'b0;
    bus.cfg_we     = 1'b0;
    bus.cfg_ch     = '0;
    bus.cfg_delay  = '0;
    bus.dinI       = '0;
    bus.dinQ       = '0;
    bus3.din_valid = 1'b0;
    bus3.cfg_we    = 1'b0;
    bus3.cfg_ch    = '0;
    bus3.cfg_delay = '0;
    bus3.dinI      = '0;
    bus3.dinQ      = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_dout_valid", 128'(bus.dout_valid), 128'(0));
    chk("rst_doutI", 128'(bus.doutI), 128'(0));
    chk("rst_doutQ", 128'(bus.doutQ), 128'(0));
    chk("rst_delay_cur", 128'(bus.delay_cur), 128'({4{5'd2}}));
    chk("rst_chan_blank", 128'(bus.chan_blank), 128'(0));

    // default delay of 2 on a continuous ramp
    for (int i = 0; i < 20; i++) cycle(1, 0, 0, 0);

    // delays 0/1/7/16, long enough to wrap the write pointer several times
    cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 1);
    cycle(0, 1, 2, 7);
    cycle(0, 1, 3, 16);
    for (int i = 0; i < 50; i++) cycle(1, 0, 0, 0);

    // delay 3 with one valid in every three clocks
    for (int c = 0; c < NCH; c++) cycle(0, 1, c, 3);
    for (int i = 0; i < 75; i++) cycle((i % 3) == 0, 0, 0, 0);

    // clamp of an oversized delay
    cycle(0, 1, 2, 31);
    cycle(0, 0, 0, 0);
    chk("clamp_ch2", 128'(bus.delay_cur[2*DW +: DW]), 128'(16));

    // config write coinciding with a valid sample
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 4);
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0);

    // asynchronous reset between clock edges, mid-stream
    cycle(1, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_dout_valid", 128'(bus.dout_valid), 128'(0));
    chk("mid_rst_doutI", 128'(bus.doutI), 128'(0));
    chk("mid_rst_doutQ", 128'(bus.doutQ), 128'(0));
    chk("mid_rst_delay_cur", 128'(bus.delay_cur), 128'({4{5'd2}}));
    model_reset();
    bus.din_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // refill from zero, then move ch1 from 2 to 5
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 5);
    for (int i = 0; i < 25; i++) cycle(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);

    // out-of-range channel on a three-channel instance
    @(negedge clk);
    bus3.cfg_we    = 1'b1;
    bus3.cfg_ch    = 2'd3;
    bus3.cfg_delay = 5'd7;
    @(negedge clk);
    bus3.cfg_we = 1'b0;
    chk("oob_ignored", 128'(bus3.delay_cur), 128'({3{5'd2}}));
    bus3.cfg_we    = 1'b1;
    bus3.cfg_ch    = 2'd2;
    bus3.cfg_delay = 5'd9;
    @(negedge clk);
    bus3.cfg_we = 1'b0;
    chk("nch3_ch2_write", 128'(bus3.delay_cur), 128'({5'd9, 5'd2, 5'd2}));

    chk("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/iq_prog_delay.md
# iq_prog_delay

Runtime-programmable, multi-channel I/Q sample delay line for the beamformer front end, generalising the fixed two-cycle delay units. Each of NCH channels carries signed I and Q samples and delays them by its own programmable number of valid samples (0..MAXD), set through a simple configuration write port. It sits between the ADC/DDC sample stream and the complex weight multipliers, providing per-element steering delays that can be changed without resetting the array.

## Interface
- W, 18, sample width of each I and Q word (signed, two's complement)
- NCH, 4, number of channels
- MAXD, 16, maximum programmable delay in samples (≥1)
- DEF_DELAY, 2, per-channel delay loaded by reset (≤MAXD)
- DW, $clog2(MAXD+1), width of delay values (derived, not overridden)

- clk  in  1  sample clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- din_valid  in  1  qualifies dinI/dinQ for all channels this cycle
- dinI  in  NCH*W  channel c at bits [c*W +: W], signed
- dinQ  in  NCH*W  same packing as dinI
- cfg_we  in  1  write strobe for delay configuration
- cfg_ch  in  $clog2(NCH) (min 1)  target channel
- cfg_delay  in  DW  new delay in samples
- dout_valid  out  1  qualifies doutI/doutQ
- doutI  out  NCH*W  delayed I, same packing
- doutQ  out  NCH*W  delayed Q, same packing
- chan_blank  out  NCH  per-channel blanking active flag
- delay_cur  out  NCH*DW  currently applied delay per channel, channel c at [c*DW +: DW]

## Operation
- Per channel: circular buffer of MAXD entries × 2W bits, shared write pointer wptr (0..MAXD-1, wraps to 0).
- Delay is counted in valid samples, not clocks; nothing advances when din_valid=0.
- On din_valid=1: for each channel c with delay D, output = input sample D valid samples ago; D=0 passes the current sample. Read index = (wptr − D) mod MAXD, taken before the write. Current sample written at wptr, then wptr increments with wrap.
- Buffer entries not yet written since reset read as zero.
- Config write: if cfg_we=1 and cfg_ch<NCH, delay[cfg_ch] ← min(cfg_delay, MAXD). cfg_ch≥NCH: write ignored, no state change. cfg_delay>MAXD: clamped to MAXD.
- cfg_we and din_valid in same cycle: that sample uses the old delay; new delay applies from the next valid sample.
- No arithmetic on samples; bit-exact passthrough of stored values, no rounding/saturation.
- Reset (async, any time including mid-stream): wptr=0, all buffer entries=0, delay[c]=DEF_DELAY, dout_valid=0, doutI/doutQ=0, chan_blank=0, blank counters=0. Stream restarts cleanly on first valid after deassertion.

## Timing
- Latency: dout_valid asserted exactly 1 clk after each din_valid=1 cycle; doutI/doutQ registered, held unchanged while dout_valid=0.
- Throughput: one sample per clock, din_valid may be high continuously.
- delay_cur updates 1 clk after the accepted cfg_we.
- Wrap-around of wptr introduces no bubble or glitch.

## Configuration
- DELAY_BLANK_EN defined: each channel has a blank counter (DW bits). A config write that changes that channel's delay loads the counter with MAXD; while nonzero, that channel's doutI/doutQ are forced to 0 and chan_blank[c]=1; counter decrements once per valid sample. Rewriting the same delay does not load it. A write during blanking reloads MAXD.
- DELAY_BLANK_EN not defined: no counters; new delay applied immediately (output may skip/repeat samples); chan_blank tied to 0.

## Test plan
- Reset defaults: NCH=4, MAXD=16; after rst, ramp dinI[c]=n+100c, continuous valid -> channel c output equals input 2 samples earlier; first two outputs 0; dout_valid lags din_valid by 1 clk.
- Per-channel delays 0/1/7/16 written, ramp input -> outputs lag by exactly 0/1/7/16 samples; delay 16 across multiple wptr wraps with no discontinuity.
- Gapped valid (1 of every 3 clocks), delay 3 -> output lags by 3 valid samples, not clocks; outputs held during gaps.
- cfg_delay=31 to ch2 -> delay_cur ch2 reads 16; cfg_ch out of range (e.g. NCH=3, cfg_ch=3) -> no delay changes; cfg_we with din_valid same cycle -> that sample uses old delay.
- DELAY_BLANK_EN: change ch1 delay 2→5 mid-stream -> ch1 output 0 and chan_blank[1]=1 for exactly 16 valid samples, then correct 5-sample lag; other channels unaffected. Without macro -> lag switches to 5 on next valid sample, chan_blank stays 0.
- Async rst asserted mid-stream between clock edges -> outputs/dout_valid go 0 immediately; after release, buffer reads zero until refilled, delays back to 2.
